// File: rtl/vga_fb_pkg.sv
`default_nettype none
// ============================================================================
// vga_fb_pkg : shared constants and grant encoding for the framebuffer arbiter
// Revision   : 1.0
// ============================================================================
package vga_fb_pkg;

   localparam int H_ACTIVE    = 640;
   localparam int V_ACTIVE    = 480;
   localparam int FB_W        = 160;
   localparam int FB_H        = 120;
   localparam int FB_DEPTH    = FB_W * FB_H;
   localparam int SCALE_SHIFT = 2;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_DISP = 2'd1,
      GNT_A    = 2'd2,
      GNT_B    = 2'd3
   } grant_e;

endpackage
`default_nettype wire

// File: rtl/vga_rr_arb2.sv
`default_nettype none
// ============================================================================
// vga_rr_arb2 : two-requester round-robin arbiter with enable, one-hot grant
// Revision    : 1.0
// ============================================================================
module vga_rr_arb2
   import vga_fb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   grant_e last_q;
   grant_e last_d;

   // bit 0 is requester A, bit 1 is requester B
   always_comb begin
      gnt_o  = 2'b00;
      last_d = last_q;
      if (en_i) begin
         if (req_i == 2'b11) begin
            gnt_o = (last_q == GNT_B) ? 2'b01 : 2'b10;
         end else begin
            gnt_o = req_i;
         end
         if (gnt_o[0]) begin
            last_d = GNT_A;
         end else if (gnt_o[1]) begin
            last_d = GNT_B;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= GNT_B;
      end else begin
         last_q <= last_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// vga_fb_arbiter : shares one single-port framebuffer RAM between VGA scan-out
//                  (priority on display slots) and two round-robin writers
// Revision       : 1.0
// ============================================================================
module vga_fb_arbiter
   import vga_fb_pkg::*;
#(
   parameter int ADDR_W        = 15,
   parameter int DATA_W        = 8,
   parameter int FB_DEPTH      = vga_fb_pkg::FB_DEPTH,
   parameter bit WR_BLANK_ONLY = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_en,
   input  logic [9:0]        counter_x,
   input  logic [9:0]        counter_y,
   input  logic              wa_req,
   input  logic [ADDR_W-1:0] wa_addr,
   input  logic [DATA_W-1:0] wa_data,
   output logic              wa_ack,
   input  logic              wb_req,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] pixel_data,
   output logic              pixel_valid,
   output logic              wr_err
);

   logic              w_in_active;
   logic              w_slot;
   logic              w_wr_slot;
   logic [7:0]        w_ys;
   logic [7:0]        w_xs;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [1:0]        w_arb_gnt;
   grant_e            w_gnt;
   logic [ADDR_W-1:0] w_win_addr;
   logic [DATA_W-1:0] w_win_data;
   logic              w_in_range;

   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              ram_we_q, ram_we_d;
   logic              wa_ack_q, wa_ack_d;
   logic              wb_ack_q, wb_ack_d;
   logic              wr_err_q, wr_err_d;
   logic [DATA_W-1:0] pixel_data_q, pixel_data_d;
   logic              pixel_valid_q, pixel_valid_d;
   logic              rd_pend_q, rd_q;
   logic              blank_pend_q, blank_q;

   // Raw counters, not the lagging registered active-area flag
   assign w_in_active = (counter_x < 10'(H_ACTIVE)) && (counter_y < 10'(V_ACTIVE));
   assign w_slot      = pix_en && w_in_active;
   assign w_wr_slot   = !w_slot && (!WR_BLANK_ONLY || !w_in_active);

   // y*160 = (y<<7) + (y<<5) on the downscaled coordinates
   assign w_ys      = 8'(counter_y >> SCALE_SHIFT);
   assign w_xs      = 8'(counter_x >> SCALE_SHIFT);
   assign w_rd_addr = (ADDR_W'(w_ys) << 7) + (ADDR_W'(w_ys) << 5) + ADDR_W'(w_xs);

   vga_rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .en_i  (w_wr_slot),
      .req_i ({wb_req, wa_req}),
      .gnt_o (w_arb_gnt)
   );

   always_comb begin
      w_gnt = GNT_NONE;
      if (w_slot) begin
         w_gnt = GNT_DISP;
      end else if (w_arb_gnt[0]) begin
         w_gnt = GNT_A;
      end else if (w_arb_gnt[1]) begin
         w_gnt = GNT_B;
      end
   end

   assign w_win_addr = (w_gnt == GNT_B) ? wb_addr : wa_addr;
   assign w_win_data = (w_gnt == GNT_B) ? wb_data : wa_data;
   assign w_in_range = w_win_addr < ADDR_W'(FB_DEPTH);

   always_comb begin
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_we_d    = 1'b0;
      wa_ack_d    = 1'b0;
      wb_ack_d    = 1'b0;
      wr_err_d    = 1'b0;
      case (w_gnt)
         GNT_DISP: begin
            ram_addr_d = w_rd_addr;
         end
         GNT_A, GNT_B: begin
            wa_ack_d = (w_gnt == GNT_A);
            wb_ack_d = (w_gnt == GNT_B);
            if (w_in_range) begin
               ram_addr_d  = w_win_addr;
               ram_wdata_d = w_win_data;
               ram_we_d    = 1'b1;
            end else begin
               wr_err_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Blank pixels travel the same 2-clk path as reads so they stay aligned
   always_comb begin
      pixel_data_d  = pixel_data_q;
      pixel_valid_d = pixel_valid_q;
      if (rd_q) begin
         pixel_data_d  = ram_rdata;
         pixel_valid_d = 1'b1;
      end else if (blank_q) begin
         pixel_data_d  = '0;
         pixel_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         ram_we_q      <= 1'b0;
         wa_ack_q      <= 1'b0;
         wb_ack_q      <= 1'b0;
         wr_err_q      <= 1'b0;
         pixel_data_q  <= '0;
         pixel_valid_q <= 1'b0;
         rd_pend_q     <= 1'b0;
         rd_q          <= 1'b0;
         blank_pend_q  <= 1'b0;
         blank_q       <= 1'b0;
      end else begin
         ram_addr_q    <= ram_addr_d;
         ram_wdata_q   <= ram_wdata_d;
         ram_we_q      <= ram_we_d;
         wa_ack_q      <= wa_ack_d;
         wb_ack_q      <= wb_ack_d;
         wr_err_q      <= wr_err_d;
         pixel_data_q  <= pixel_data_d;
         pixel_valid_q <= pixel_valid_d;
         rd_pend_q     <= w_slot;
         rd_q          <= rd_pend_q;
         blank_pend_q  <= pix_en && !w_slot;
         blank_q       <= blank_pend_q;
      end
   end

   assign ram_addr    = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;
   assign ram_we      = ram_we_q;
   assign wa_ack      = wa_ack_q;
   assign wb_ack      = wb_ack_q;
   assign wr_err      = wr_err_q;
   assign pixel_data  = pixel_data_q;
   assign pixel_valid = pixel_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vga_fb_arbiter : directed + randomized bench with a framebuffer reference
// Revision          : 1.0
// ============================================================================
module tb_vga_fb_arbiter;

   localparam int FB_N = 19200;

   typedef struct {
      int         due;
      logic [7:0] v;
      logic       valid;
   } pix_t;

   logic        clk;
   logic        rst;
   logic        pix_en;
   logic [9:0]  cx, cy;
   logic        wa_req, wb_req;
   logic [14:0] wa_addr, wb_addr;
   logic [7:0]  wa_data, wb_data;
   logic        wa_ack, wb_ack, ram_we, wr_err, pixel_valid;
   logic [14:0] ram_addr;
   logic [7:0]  ram_wdata, ram_rdata, pixel_data;

   logic        wa2_req, wb2_req;
   logic [14:0] wa2_addr, wb2_addr;
   logic [7:0]  wa2_data, wb2_data, rdata2;
   logic        wa2_ack, wb2_ack, ram_we2, wr_err2, pixel_valid2;
   logic [14:0] ram_addr2;
   logic [7:0]  ram_wdata2, pixel_data2;

   int          vec, miss, ecnt;
   logic [7:0]  mem [FB_N];
   logic [7:0]  fb  [FB_N];
   pix_t        pq [$];

   int          m_last;
   logic [14:0] m_addr;
   logic [7:0]  m_wdata, m_pix;
   logic        m_we, m_acka, m_ackb, m_err, m_val;
   logic        done;

   vga_fb_arbiter u_dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .counter_x(cx), .counter_y(cy),
      .wa_req(wa_req), .wa_addr(wa_addr), .wa_data(wa_data), .wa_ack(wa_ack),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .pixel_data(pixel_data), .pixel_valid(pixel_valid), .wr_err(wr_err)
   );

   vga_fb_arbiter #(.WR_BLANK_ONLY(1'b1)) u_dut_wbo (
      .clk(clk), .rst(rst), .pix_en(pix_en), .counter_x(cx), .counter_y(cy),
      .wa_req(wa2_req), .wa_addr(wa2_addr), .wa_data(wa2_data), .wa_ack(wa2_ack),
      .wb_req(wb2_req), .wb_addr(wb2_addr), .wb_data(wb2_data), .wb_ack(wb2_ack),
      .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_we(ram_we2), .ram_rdata(rdata2),
      .pixel_data(pixel_data2), .pixel_valid(pixel_valid2), .wr_err(wr_err2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_last  = 1;
      m_addr  = '0;
      m_wdata = '0;
      m_we    = 1'b0;
      m_acka  = 1'b0;
      m_ackb  = 1'b0;
      m_err   = 1'b0;
      m_pix   = '0;
      m_val   = 1'b0;
      pq.delete();
   endtask

   // Reference: slot -> pixel two edges later; writers share the other edges
   task automatic model_step();
      bit          slot;
      int          win;
      int          ra;
      logic [14:0] a;
      logic [7:0]  d;
      if (rst) begin
         model_reset();
         return;
      end
      ecnt++;
      slot   = pix_en && (int'(cx) < 640) && (int'(cy) < 480);
      m_we   = 1'b0;
      m_acka = 1'b0;
      m_ackb = 1'b0;
      m_err  = 1'b0;
      if (pq.size() > 0 && pq[0].due == ecnt) begin
         m_pix = pq[0].v;
         m_val = pq[0].valid;
         void'(pq.pop_front());
      end
      if (slot) begin
         ra     = (int'(cy) / 4) * 160 + int'(cx) / 4;
         m_addr = 15'(ra);
         pq.push_back('{ecnt + 2, fb[ra], 1'b1});
      end else begin
         if (pix_en) pq.push_back('{ecnt + 2, 8'h00, 1'b0});
         win = -1;
         if (wa_req && wb_req) win = (m_last == 1) ? 0 : 1;
         else if (wa_req)      win = 0;
         else if (wb_req)      win = 1;
         if (win >= 0) begin
            m_last = win;
            a = (win == 0) ? wa_addr : wb_addr;
            d = (win == 0) ? wa_data : wb_data;
            if (win == 0) m_acka = 1'b1; else m_ackb = 1'b1;
            if (int'(a) < FB_N) begin
               m_addr  = a;
               m_wdata = d;
               m_we    = 1'b1;
               fb[a]   = d;
            end else begin
               m_err = 1'b1;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("ram_we",      32'(ram_we),      32'(m_we));
      chk("wa_ack",      32'(wa_ack),      32'(m_acka));
      chk("wb_ack",      32'(wb_ack),      32'(m_ackb));
      chk("wr_err",      32'(wr_err),      32'(m_err));
      chk("ram_addr",    32'(ram_addr),    32'(m_addr));
      chk("ram_wdata",   32'(ram_wdata),   32'(m_wdata));
      chk("pixel_data",  32'(pixel_data),  32'(m_pix));
      chk("pixel_valid", 32'(pixel_valid), 32'(m_val));
   endtask

   // One clock edge: synchronous read-first RAM, reference step, comparison
   task automatic tick();
      logic [14:0] a_s;
      logic [7:0]  wd_s, old;
      logic        we_s;
      a_s  = ram_addr;
      we_s = ram_we;
      wd_s = ram_wdata;
      @(posedge clk);
      #1;
      old = (int'(a_s) < FB_N) ? mem[a_s] : 8'h00;
      if (we_s && int'(a_s) < FB_N) mem[a_s] = wd_s;
      ram_rdata = old;
      model_step();
      check_all();
   endtask

   function automatic logic [14:0] rnd_addr();
      int r;
      r = $urandom_range(0, 7);
      case (r)
         0:       return 15'd19199;
         1:       return 15'd19200;
         2:       return 15'($urandom_range(19201, 32767));
         default: return 15'($urandom_range(0, FB_N - 1));
      endcase
   endfunction

   task automatic drive_writers();
      if (m_acka) begin
         wa_req  = ($urandom_range(0, 1) == 1);
         wa_addr = rnd_addr();
         wa_data = 8'($urandom);
      end else if (!wa_req && $urandom_range(0, 2) == 0) begin
         wa_req  = 1'b1;
         wa_addr = rnd_addr();
         wa_data = 8'($urandom);
      end
      if (m_ackb) begin
         wb_req  = ($urandom_range(0, 1) == 1);
         wb_addr = rnd_addr();
         wb_data = 8'($urandom);
      end else if (!wb_req && $urandom_range(0, 2) == 0) begin
         wb_req  = 1'b1;
         wb_addr = rnd_addr();
         wb_data = 8'($urandom);
      end
   endtask

   initial begin
      vec = 0; miss = 0; ecnt = 0;
      for (int i = 0; i < FB_N; i++) begin
         mem[i] = 8'($urandom);
         fb[i]  = mem[i];
      end
      ram_rdata = 8'h00;
      rdata2    = 8'h00;
      wa2_req = 1'b0; wa2_addr = '0; wa2_data = '0;
      wb2_req = 1'b0; wb2_addr = '0; wb2_data = '0;
      pix_en = 1'b0; cx = 10'd700; cy = 10'd10;
      wa_req = 1'b1; wa_addr = 15'd10; wa_data = 8'h11;
      wb_req = 1'b1; wb_addr = 15'd20; wb_data = 8'h22;
      rst = 1'b0;
      model_reset();

      // Reset with both writers requesting, then A, B, A alternation
      #2 rst = 1'b1;
      #1 check_all();
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("rr_first_a", 32'(wa_ack), 32'd1);
      chk("rr_first_b", 32'(wb_ack), 32'd0);
      wa_addr = 15'd11; wa_data = 8'h12;
      tick();
      chk("rr_second_b", 32'(wb_ack), 32'd1);
      wb_addr = 15'd21; wb_data = 8'h23;
      tick();
      chk("rr_third_a", 32'(wa_ack), 32'd1);
      wa_req = 1'b0;
      tick();
      chk("rr_fourth_b", 32'(wb_ack), 32'd1);
      wb_req = 1'b0;

      // Display read at (8,4) -> address 162, pixel 2 clk later
      wa_req = 1'b1; wa_addr = 15'd162; wa_data = 8'h5A;
      tick();
      wa_req = 1'b0;
      pix_en = 1'b1; cx = 10'd8; cy = 10'd4;
      tick();
      chk("slot_addr", 32'(ram_addr), 32'd162);
      chk("slot_we",   32'(ram_we),   32'd0);
      pix_en = 1'b0;
      tick();
      pix_en = 1'b1; cx = 10'd700;
      tick();
      chk("slot_pix",   32'(pixel_data),  32'h5A);
      chk("slot_valid", 32'(pixel_valid), 32'd1);

      // Writer colliding with a display slot waits one edge
      pix_en = 1'b1; cx = 10'd8; cy = 10'd4;
      wa_req = 1'b1; wa_addr = 15'd100; wa_data = 8'h33;
      tick();
      chk("collide_noack", 32'(wa_ack), 32'd0);
      pix_en = 1'b0;
      tick();
      chk("collide_ack",   32'(wa_ack),    32'd1);
      chk("collide_we",    32'(ram_we),    32'd1);
      chk("collide_addr",  32'(ram_addr),  32'd100);
      chk("collide_wdata", 32'(ram_wdata), 32'h33);
      wa_req = 1'b0;

      // Range boundary
      cx = 10'd700;
      wb_req = 1'b1; wb_addr = 15'd19200; wb_data = 8'h77;
      tick();
      chk("oob_ack", 32'(wb_ack), 32'd1);
      chk("oob_err", 32'(wr_err), 32'd1);
      chk("oob_we",  32'(ram_we), 32'd0);
      wb_addr = 15'd19199; wb_data = 8'h78;
      tick();
      chk("edge_ack",  32'(wb_ack),   32'd1);
      chk("edge_we",   32'(ram_we),   32'd1);
      chk("edge_err",  32'(wr_err),   32'd0);
      chk("edge_addr", 32'(ram_addr), 32'd19199);
      wb_req = 1'b0;
      tick();
      chk("pulse_clear", 32'(ram_we), 32'd0);

      // Blank-only writer held off until the line leaves the active area
      cy = 10'd100; cx = 10'd10; pix_en = 1'b1;
      wa2_req = 1'b1; wa2_addr = 15'd500; wa2_data = 8'h44;
      done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         tick();
         chk("wbo_pvalid", 32'(pixel_valid2), 32'(m_val));
         if (int'(cx) < 640) begin
            chk("wbo_wait", 32'(wa2_ack), 32'd0);
         end else begin
            chk("wbo_ack",   32'(wa2_ack),    32'd1);
            chk("wbo_we",    32'(ram_we2),    32'd1);
            chk("wbo_addr",  32'(ram_addr2),  32'd500);
            chk("wbo_wdata", 32'(ram_wdata2), 32'h44);
            chk("wbo_err",   32'(wr_err2),    32'd0);
            chk("wbo_bak",   32'(wb2_ack),    32'd0);
            chk("wbo_pix",   32'(pixel_data2), 32'd0);
            done = 1'b1;
         end
         pix_en = ~pix_en;
         if (pix_en) cx = cx + 10'd30;
      end
      chk("wbo_reached", 32'(done), 32'd1);
      wa2_req = 1'b0;
      tick();
      chk("wbo_ack_clear", 32'(wa2_ack), 32'd0);

      // Blanking pixel is black; reset mid-read drops the pending pixel
      cx = 10'd700; cy = 10'd10; pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      tick();
      chk("blank_pix",   32'(pixel_data),  32'd0);
      chk("blank_valid", 32'(pixel_valid), 32'd0);
      cx = 10'd20; cy = 10'd40;
      for (int n = 0; n < 4; n++) begin
         pix_en = (n % 2 == 0);
         tick();
      end
      chk("pre_rst_valid", 32'(pixel_valid), 32'd1);
      pix_en = 1'b1;
      tick();
      #2 rst = 1'b1;
      #1 model_reset();
      chk("rst_valid", 32'(pixel_valid), 32'd0);
      check_all();
      @(negedge clk);
      rst = 1'b0;
      pix_en = 1'b0;
      tick();
      tick();
      chk("post_rst_valid", 32'(pixel_valid), 32'd0);

      // Randomized traffic against the reference
      for (int p = 0; p < 1500; p++) begin
         cx = 10'($urandom_range(0, 799));
         cy = 10'($urandom_range(0, 524));
         for (int h = 0; h < 2; h++) begin
            pix_en = (h == 0);
            tick();
            drive_writers();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares one single-port framebuffer RAM (160x120, 8-bit pixels, 19200 words) between two masters: the VGA scan-out and two writer ports, A and B.
- Sits between the VGA sync generator (which supplies pixel counters and a pixel-rate enable) and the framebuffer RAM.
- Scan-out reads always win on display-slot cycles.
- Writers share the remaining cycles round-robin.
- Each output pixel is a 4x4 upscale of one framebuffer word, giving 640x480.

Parameters:
- ADDR_W, 15, framebuffer address width.
- DATA_W, 8, pixel/word width.
- FB_DEPTH, 19200, number of valid framebuffer words (160*120).
- WR_BLANK_ONLY, 0, 1 = writers granted only on cycles outside the active area.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- pix_en  in  1  pixel-rate enable, high every second clk (25 MHz pixel rate).
- counter_x  in  10  horizontal pixel counter from the sync generator.
- counter_y  in  10  vertical pixel counter from the sync generator.
- wa_req  in  1  writer A request; held until ack.
- wa_addr  in  ADDR_W  writer A address.
- wa_data  in  DATA_W  writer A data.
- wa_ack  out  1  writer A write accepted, 1-cycle pulse.
- wb_req, wb_addr, wb_data, wb_ack: as writer A, for writer B.
- ram_addr  out  ADDR_W  RAM address, registered.
- ram_wdata  out  DATA_W  RAM write data, registered.
- ram_we  out  1  RAM write enable, registered.
- ram_rdata  in  DATA_W  RAM read data, valid 1 clk after ram_addr.
- pixel_data  out  DATA_W  pixel to the DAC, registered.
- pixel_valid  out  1  pixel_data belongs to the active area.
- wr_err  out  1  1-cycle pulse: acked write was out of range and dropped.

Behaviour:
- Reset:
  - All outputs are 0.
  - Last-grant flag = B, so A wins the first tie.
  - The read pipeline flag is cleared.
  - Pending requests are not remembered; requesters keep req high and are served after reset releases.
- Display slot: clk edge where pix_en=1, counter_x<640 and counter_y<480.
  - Counters are used directly; the registered InDisplayArea is not used, because it lags.
  - On a slot: ram_addr <= (counter_y>>2)*160 + (counter_x>>2), ram_we <= 0, rd_pend <= 1.
  - The multiply is implemented as (y<<7)+(y<<5) with 8-bit y>>2; no multiplier.
- Read return: on the edge where rd_q (rd_pend delayed 1 clk) is 1, pixel_data <= ram_rdata and pixel_valid <= 1.
  - Total latency from slot edge to pixel_data update: 2 clk = 1 pixel period.
- Blanking pixels: at a pix_en edge that is not a display slot, pixel_data <= 0 and pixel_valid <= 0 at the same 2-clk delay, so blank pixels are guaranteed black.
- Writer slot: any edge that is not a display slot. When WR_BLANK_ONLY=1, the edge must also have counter_x>=640 or counter_y>=480.
- Arbitration on a writer slot:
  - Only one requester: it wins.
  - Both requesting: the one not granted last wins; the last-grant flag updates on every grant.
  - Neither requesting: ram_we <= 0 and ram_addr holds its value.
- Winner, address < FB_DEPTH: ram_addr/ram_wdata <= winner's addr/data, ram_we <= 1, winner ack <= 1, all on the same edge.
- Winner, address >= FB_DEPTH: ack <= 1, wr_err <= 1, ram_we <= 0. The write is dropped.
- ram_we, wa_ack, wb_ack and wr_err are 1-cycle pulses, cleared on the next edge unless re-granted.
- Requester protocol: addr/data must be stable while req=1.
  - On the cycle after ack, a requester may keep req high for a back-to-back write with new addr/data.
  - Under contention, round-robin guarantees alternation.
- Display slot collides with a writer request: the display wins; the writer waits, and its ack is delayed by at least one cycle.
- Worst-case writer wait:
  - In active area: 3 clk.
  - With WR_BLANK_ONLY=1: up to the end of the active line.
- Counter wrap (800/525 to 0) needs no special handling; the slot condition is purely combinational on the counters.
- An asynchronous reset mid-read discards the pending pixel; pixel_valid stays 0 until the next read returns.

Decomposition:
- Package vga_fb_pkg holds:
  - H_ACTIVE=640, V_ACTIVE=480, FB_W=160, FB_H=120, FB_DEPTH, SCALE_SHIFT=2.
  - The grant enum {GNT_NONE, GNT_DISP, GNT_A, GNT_B}.
- One sub-module: vga_rr_arb2.
  - Two-requester round-robin with enable input and last-grant register.
  - Returns a one-hot grant.
- Address calculation and the read pipeline stay in the top module.

Test Plan:
1. Reset with wa_req=wb_req=1 held -> all outputs 0 during reset; after release the first writer grant goes to A, then B, then A (alternating acks).
2. counter_x=8, counter_y=4, pix_en=1, no writers -> ram_addr=162, ram_we=0; with ram_rdata=0x5A, pixel_data=0x5A and pixel_valid=1 exactly 2 clk later.
3. wa_req=1, wa_addr=100, wa_data=0x33 on a display-slot edge -> no ack on that edge; wa_ack=1, ram_we=1, ram_addr=100, ram_wdata=0x33 on the next non-slot edge.
4. wb_addr=19200 -> wb_ack=1 and wr_err=1 for one cycle, ram_we=0; wb_addr=19199 -> normal write, wr_err=0.
5. WR_BLANK_ONLY=1, wa_req during counter_y=100, counter_x=10 -> no ack until counter_x reaches 640, then ack on the first edge.
6. Full frame at counter_x=700 (blanking), pix_en=1 -> pixel_data=0 and pixel_valid=0; async rst asserted mid-read -> pixel_valid=0 immediately.
